// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder block.
package dmem_pkg;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = 32;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE
    } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake between the core (master) and the data memory (slave).
interface data_mem_responder_if;
    import dmem_pkg::*;

    logic  RRam;
    logic  WRam;
    word_t daddr;
    word_t ddata_w;
    word_t ddata_r;
    logic  done_ext;
    logic  busy;
    logic  err;

    modport master (
        output RRam, WRam, daddr, ddata_w,
        input  ddata_r, done_ext, busy, err
    );

    modport slave (
        input  RRam, WRam, daddr, ddata_w,
        output ddata_r, done_ext, busy, err
    );

endinterface

// File: rtl/data_mem_responder_sp_word_ram.sv
// Single-port word RAM: synchronous write, synchronous read (old data on same-address write), no storage reset.
module sp_word_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  word_t                 wdata,
    output word_t                 rdata
);

    word_t mem [0:(2**DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one read/write request, waits WAIT_CYCLES, services it from
// the on-chip RAM and answers with a one-cycle done_ext (plus err for bad requests).
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter word_t       BASE_ADDR   = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    data_mem_responder_if.slave  bus
);

    localparam cnt_t WAIT_INIT = cnt_t'(WAIT_CYCLES);

    state_t                state;
    cnt_t                  cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    word_t                 wdata_q;
    logic                  write_q;
    logic                  oor_q;
    logic                  flag_q;
    word_t                 rdata_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  err_q;

    word_t                 off;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  req_in_range;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic                  ram_we;
    word_t                 ram_rdata;

    // In IDLE the RAM is addressed straight from the bus so read data is ready by ACCESS even with no wait states.
    always_comb begin
        off          = bus.daddr - BASE_ADDR;
        req_idx      = off[DEPTH_LOG2+1:2];
        req_in_range = ((off >> (DEPTH_LOG2 + 2)) == 32'd0);
        ram_addr     = (state == IDLE) ? req_idx : idx_q;
        ram_we       = (state == ACCESS) && write_q && !oor_q && !RST;
    end

    sp_word_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            oor_q   <= 1'b0;
            flag_q  <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.RRam || bus.WRam) begin
                        idx_q   <= req_idx;
                        wdata_q <= bus.ddata_w;
                        write_q <= bus.WRam;
                        oor_q   <= !req_in_range;
                        flag_q  <= !req_in_range || (bus.RRam && bus.WRam);
                        cnt     <= WAIT_INIT;
                        busy_q  <= 1'b1;
                        state   <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == cnt_t'(1)) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!write_q) begin
                        rdata_q <= oor_q ? '0 : ram_rdata;
                    end
                    done_q <= 1'b1;
                    err_q  <= flag_q;
                    state  <= DONE;
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ddata_r  = rdata_q;
    assign bus.done_ext = done_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder with two instances: 0 wait states and 2 wait states.
module tb_data_mem_responder;

    typedef struct {
        int          sel;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t        sbq [$];
    logic [31:0] last_rd [2];
    logic [31:0] mdl [2][1024];
    int          wait_of [2] = '{0, 2};

    always #5 clk = ~clk;

    data_mem_responder_if bus_w0 ();
    data_mem_responder_if bus_w2 ();

    data_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_w0 (
        .CLK (clk),
        .RST (rst),
        .bus (bus_w0.slave)
    );

    data_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut_w2 (
        .CLK (clk),
        .RST (rst),
        .bus (bus_w2.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int sel, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus_w0.RRam = r; bus_w0.WRam = w; bus_w0.daddr = a; bus_w0.ddata_w = d;
        end else begin
            bus_w2.RRam = r; bus_w2.WRam = w; bus_w2.daddr = a; bus_w2.ddata_w = d;
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 0) ? bus_w0.done_ext : bus_w2.done_ext;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bus_w0.busy : bus_w2.busy;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == 0) ? bus_w0.err : bus_w2.err;
    endfunction

    function automatic logic [31:0] get_rd(input int sel);
        return (sel == 0) ? bus_w0.ddata_r : bus_w2.ddata_r;
    endfunction

    // Called mid-cycle; b2b marks a request raised in the DONE cycle of the previous one.
    task automatic access(input int sel, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input int b2b);
        exp_t        e;
        logic [31:0] off;
        logic [9:0]  idx;
        bit          inr;
        bit          seen;
        int          lat;
        off   = a;
        idx   = off[11:2];
        inr   = (off < 32'h1000);
        e.sel = sel;
        e.err = !inr || (r && w);
        e.lat = wait_of[sel] + 2 + b2b;
        if (w) begin
            if (inr) mdl[sel][idx] = d;
            e.rdata = last_rd[sel];
        end else begin
            e.rdata = inr ? mdl[sel][idx] : 32'h0;
            last_rd[sel] = e.rdata;
        end
        sbq.push_back(e);

        set_req(sel, r, w, a, d);
        seen = 0;
        lat  = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (i == 1 + b2b) check("busy_start", get_busy(sel), 1'b1);
            if (get_done(sel)) begin
                seen = 1;
                lat  = i;
            end
        end
        set_req(sel, 1'b0, 1'b0, a, d);

        e = sbq.pop_front();
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(lat), 32'(e.lat));
            check("err", get_err(e.sel), e.err);
            check("ddata_r", get_rd(e.sel), e.rdata);
            check("busy_done", get_busy(e.sel), 1'b1);
        end
    endtask

    task automatic idle_check(input int sel);
        @(posedge clk); #1;
        check("done_pulse_width", get_done(sel), 1'b0);
        check("busy_idle", get_busy(sel), 1'b0);
    endtask

    task automatic reset_outputs_check(input string tag);
        for (int s = 0; s < 2; s++) begin
            check({tag, "_done"}, get_done(s), 1'b0);
            check({tag, "_busy"}, get_busy(s), 1'b0);
            check({tag, "_err"}, get_err(s), 1'b0);
            check({tag, "_ddata_r"}, get_rd(s), 32'h0);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            last_rd[s] = 32'h0;
            for (int k = 0; k < 1024; k++) mdl[s][k] = 32'h0;
        end

        // Reset held with a pending read request
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            reset_outputs_check("reset");
        end
        rst = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        reset_outputs_check("post_reset");

        // Write then read, two wait states
        access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        idle_check(1);
        access(1, 1'b1, 1'b0, 32'h10, 32'h0, 0);
        idle_check(1);

        // Zero wait states, back-to-back reads
        access(0, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 0);
        idle_check(0);
        access(0, 1'b0, 1'b1, 32'h4, 32'hCAFE0004, 0);
        idle_check(0);
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, 0);
        access(0, 1'b1, 1'b0, 32'h4, 32'h0, 1);
        idle_check(0);

        // Out-of-range accesses and the last in-range word
        access(1, 1'b0, 1'b1, 32'h0, 32'h12345678, 0);
        idle_check(1);
        access(1, 1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 0);
        idle_check(1);
        access(1, 1'b1, 1'b0, 32'h0, 32'h0, 0);
        idle_check(1);
        access(1, 1'b1, 1'b0, 32'h1000, 32'h0, 0);
        idle_check(1);
        access(1, 1'b0, 1'b1, 32'hFFC, 32'h600DCAFE, 0);
        idle_check(1);
        access(1, 1'b1, 1'b0, 32'hFFC, 32'h0, 0);
        idle_check(1);

        // Read and write together: treated as a flagged write
        access(1, 1'b1, 1'b1, 32'h20, 32'h5, 0);
        idle_check(1);
        access(1, 1'b1, 1'b0, 32'h20, 32'h0, 0);
        idle_check(1);

        // Reset during the wait states of a write aborts it
        access(1, 1'b0, 1'b1, 32'h30, 32'h00001111, 0);
        idle_check(1);
        set_req(1, 1'b0, 1'b1, 32'h30, 32'h0000A5A5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        set_req(1, 1'b0, 1'b0, 32'h30, 32'h0000A5A5);
        @(posedge clk); #1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        reset_outputs_check("mid_wait_reset");
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("aborted_done", get_done(1), 1'b0);
        end
        access(1, 1'b1, 1'b0, 32'h30, 32'h0, 0);
        idle_check(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
